// File: rtl/hack_mem_arbiter.sv
// Purpose: two-master arbiter in front of the single-port Hack data memory (RAM16K, screen, keyboard).
// Latency: the memory access is registered one cycle after the transfer; read data and rvalid follow one cycle later (2 cycles in total).
// Backpressure: each port stalls through a low gnt. A wins by default, and B is forced in once it has waited B_STARVE_LIMIT A grants.
//
// Ports:
//   clk, reset              - clock; asynchronous active-high reset
//   a_* / b_*               - requester ports: req/we/addr/wdata in, gnt (comb), rdata/rvalid out
//   mem_in/mem_address/mem_load - registered access driven to the memory block
//   mem_out                 - combinational read data from the memory block
//   bad_addr                - one-cycle pulse for a dropped write or an unmapped read
module hack_mem_arbiter #(
  parameter int unsigned B_STARVE_LIMIT = 4,
  parameter logic [14:0] KBD_ADDR       = 15'h6000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [14:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic [15:0] a_rdata,
  output logic        a_rvalid,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [14:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic [15:0] b_rdata,
  output logic        b_rvalid,
  output logic [15:0] mem_in,
  output logic [14:0] mem_address,
  output logic        mem_load,
  input  logic [15:0] mem_out,
  output logic        bad_addr
);

  localparam logic [3:0] LIMIT = 4'(B_STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        b_prio;
  logic        xfer;
  logic        x_we;
  logic [14:0] x_addr;
  logic [15:0] x_wdata;
  logic        x_below_kbd;
  logic        x_unmapped;
  logic        x_bad;

  // Pending-read tag carried from the transfer cycle into the memory cycle
  logic        rd_pend;
  logic        rd_port_b;
  logic        rd_zero;
  logic [15:0] rd_val;

  assign b_prio = (starve_cnt >= LIMIT);

  // Grants are gated by reset so that nothing is accepted while the pipeline is being cleared
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (a_req && (!b_req || !b_prio)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  assign xfer    = a_gnt | b_gnt;
  assign x_we    = b_gnt ? b_we    : a_we;
  assign x_addr  = b_gnt ? b_addr  : a_addr;
  assign x_wdata = b_gnt ? b_wdata : a_wdata;

  assign x_below_kbd = (x_addr < KBD_ADDR);
  assign x_unmapped  = (x_addr > KBD_ADDR);
  // The keyboard register is read-only, so any write at or above it is illegal
  assign x_bad       = xfer & (x_we ? !x_below_kbd : x_unmapped);

  // Starvation counter: counts A wins while B waits, and saturates so that B keeps priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (b_gnt || !b_req) begin
      starve_cnt <= 4'd0;
    end else if (a_gnt && (starve_cnt != 4'd15)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Access stage: register the winning request toward the memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_address <= '0;
      mem_in      <= '0;
      mem_load    <= 1'b0;
      bad_addr    <= 1'b0;
      rd_pend     <= 1'b0;
      rd_port_b   <= 1'b0;
      rd_zero     <= 1'b0;
    end else begin
      mem_load  <= xfer & x_we & x_below_kbd;
      bad_addr  <= x_bad;
      rd_pend   <= xfer & !x_we;
      rd_port_b <= b_gnt;
      rd_zero   <= x_unmapped;
      if (xfer) begin
        mem_address <= x_addr;
        mem_in      <= x_wdata;
      end
    end
  end

  assign rd_val = rd_zero ? 16'h0000 : mem_out;

  // Return stage: steer the read data to the port named by the tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata  <= '0;
      b_rdata  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= rd_pend & !rd_port_b;
      b_rvalid <= rd_pend & rd_port_b;
      if (rd_pend && !rd_port_b) begin
        a_rdata <= rd_val;
      end
      if (rd_pend && rd_port_b) begin
        b_rdata <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Purpose: directed self-checking bench for hack_mem_arbiter with a behavioural Hack memory model.
// Latency: observations are taken 1-4 time units after each rising edge.
// Backpressure: the requests are driven directly; the grant pattern is checked against hand-computed tables.
module tb_hack_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [14:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] mem_in, mem_out;
  logic [14:0] mem_address;
  logic        mem_load;
  logic        bad_addr;

  // Memory model: a write commits on the edge after mem_load is seen, and reads are combinational.
  // The preload port seeds contents such as the keyboard value 0x0041 at 0x6000.
  logic [15:0] mem [0:32767];
  logic        pre_we;
  logic [14:0] pre_addr;
  logic [15:0] pre_dat;

  always @(posedge clk) begin
    if (mem_load) mem[mem_address] <= mem_in;
    else if (pre_we) mem[pre_addr] <= pre_dat;
  end
  assign mem_out = mem[mem_address];

  int vectors;
  int miscompares;
  logic [9:0] pat;

  hack_mem_arbiter #(.B_STARVE_LIMIT(4), .KBD_ADDR(15'h6000)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_in(mem_in), .mem_address(mem_address), .mem_load(mem_load),
    .mem_out(mem_out), .bad_addr(bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    tick();
    pre_we = 1'b1; pre_addr = 15'h0000; pre_dat = 16'hBEEF; tick();
    pre_addr = 15'h6000; pre_dat = 16'h0041; tick();
    pre_addr = 15'h6001; pre_dat = 16'hDEAD; tick();
    pre_we = 1'b0;

    // Reset state, with both requests raised to show that the grants stay low
    a_req = 1'b1; b_req = 1'b1; #1;
    chk1("rst_a_gnt", a_gnt, 1'b0);
    chk1("rst_b_gnt", b_gnt, 1'b0);
    chk1("rst_mem_load", mem_load, 1'b0);
    chk1("rst_a_rvalid", a_rvalid, 1'b0);
    chk1("rst_b_rvalid", b_rvalid, 1'b0);
    chk1("rst_bad_addr", bad_addr, 1'b0);
    chk16("rst_mem_in", mem_in, 16'h0000);
    chk16("rst_mem_address", {1'b0, mem_address}, 16'h0000);
    chk16("rst_a_rdata", a_rdata, 16'h0000);
    chk16("rst_b_rdata", b_rdata, 16'h0000);
    a_req = 1'b0; b_req = 1'b0; reset = 1'b0;

    // A writes 0x1234 to 0x0010, then reads it back
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0010; a_wdata = 16'h1234; #1;
    chk1("wr_a_gnt", a_gnt, 1'b1);
    chk1("wr_b_gnt", b_gnt, 1'b0);
    tick();
    chk1("wr_mem_load", mem_load, 1'b1);
    chk16("wr_mem_address", {1'b0, mem_address}, 16'h0010);
    chk16("wr_mem_in", mem_in, 16'h1234);
    a_we = 1'b0; #1;
    chk1("rd_a_gnt", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    chk1("rd_mem_load_off", mem_load, 1'b0);
    chk1("rd_early_rvalid", a_rvalid, 1'b0);
    tick();
    chk1("rd_a_rvalid", a_rvalid, 1'b1);
    chk16("rd_a_rdata", a_rdata, 16'h1234);
    chk1("rd_b_rvalid", b_rvalid, 1'b0);
    tick();
    chk1("rd_a_rvalid_pulse", a_rvalid, 1'b0);
    chk16("rd_a_rdata_hold", a_rdata, 16'h1234);

    // Reset asserted mid-cycle while mem_load is high and a B read is being granted
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0020; a_wdata = 16'h5555;
    tick();
    chk1("mid_mem_load_pre", mem_load, 1'b1);
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0010; #1;
    chk1("mid_b_gnt_pre", b_gnt, 1'b1);
    #1 reset = 1'b1; a_req = 1'b1; #1;
    chk1("mid_mem_load", mem_load, 1'b0);
    chk1("mid_a_gnt", a_gnt, 1'b0);
    chk1("mid_b_gnt", b_gnt, 1'b0);
    chk1("mid_bad_addr", bad_addr, 1'b0);
    chk1("mid_a_rvalid", a_rvalid, 1'b0);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0000; #1;
    chk1("post_a_gnt", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    chk1("post_a_rvalid_n1", a_rvalid, 1'b0);
    chk1("post_b_rvalid_n1", b_rvalid, 1'b0);
    tick();
    chk1("post_a_rvalid", a_rvalid, 1'b1);
    chk16("post_a_rdata", a_rdata, 16'hBEEF);
    chk1("post_b_rvalid", b_rvalid, 1'b0);

    // Both ports read continuously: grants go A,A,A,A,B, and each rvalid lands 2 cycles after its grant
    pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      tick();
      a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010;
      b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0000; #1;
      chk1("arb_a_gnt", a_gnt, !pat[i]);
      chk1("arb_b_gnt", b_gnt, pat[i]);
      if (i >= 2) begin
        chk1("arb_a_rvalid", a_rvalid, !pat[i-2]);
        chk1("arb_b_rvalid", b_rvalid, pat[i-2]);
      end
    end
    tick();
    a_req = 1'b0; b_req = 1'b0;
    chk1("arb_tail_a_rvalid", a_rvalid, 1'b1);
    chk1("arb_tail_b_rvalid0", b_rvalid, 1'b0);
    tick();
    chk1("arb_tail_b_rvalid", b_rvalid, 1'b1);
    chk16("arb_tail_b_rdata", b_rdata, 16'hBEEF);
    chk1("arb_tail_a_rvalid0", a_rvalid, 1'b0);
    chk16("arb_tail_a_rdata", a_rdata, 16'h1234);
    tick();
    chk1("arb_idle_b_rvalid", b_rvalid, 1'b0);

    // Keyboard: the read returns 0x0041, and a write to it is dropped and flagged
    tick();
    b_req = 1'b1; b_we = 1'b0; b_addr = 15'h6000; #1;
    chk1("kbd_b_gnt", b_gnt, 1'b1);
    tick();
    b_req = 1'b0;
    chk1("kbd_rd_bad_addr", bad_addr, 1'b0);
    tick();
    chk1("kbd_b_rvalid", b_rvalid, 1'b1);
    chk16("kbd_b_rdata", b_rdata, 16'h0041);
    tick();
    b_req = 1'b1; b_we = 1'b1; b_wdata = 16'hFFFF; #1;
    chk1("kbd_wr_b_gnt", b_gnt, 1'b1);
    tick();
    b_req = 1'b0; b_we = 1'b0;
    chk1("kbd_wr_mem_load", mem_load, 1'b0);
    chk1("kbd_wr_bad_addr", bad_addr, 1'b1);
    tick();
    chk1("kbd_wr_bad_pulse", bad_addr, 1'b0);
    chk1("kbd_wr_no_rvalid", b_rvalid, 1'b0);
    tick();
    b_req = 1'b1; b_addr = 15'h6000;
    tick();
    b_req = 1'b0;
    tick();
    chk1("kbd_rd2_b_rvalid", b_rvalid, 1'b1);
    chk16("kbd_rd2_b_rdata", b_rdata, 16'h0041);

    // Unmapped space: a read returns 0 with rvalid and is flagged; a write is dropped and flagged
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h6001; #1;
    chk1("unm_a_gnt", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    chk1("unm_rd_bad_addr", bad_addr, 1'b1);
    tick();
    chk1("unm_a_rvalid", a_rvalid, 1'b1);
    chk16("unm_a_rdata", a_rdata, 16'h0000);
    chk1("unm_rd_bad_pulse", bad_addr, 1'b0);
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h5FFF; a_wdata = 16'h5A5A;
    tick();
    a_addr = 15'h7FFF; a_wdata = 16'h1111;
    chk1("scr_top_mem_load", mem_load, 1'b1);
    chk1("scr_top_bad_addr", bad_addr, 1'b0);
    tick();
    a_req = 1'b0; a_we = 1'b0;
    chk1("unm_wr_mem_load", mem_load, 1'b0);
    chk1("unm_wr_bad_addr", bad_addr, 1'b1);
    chk16("unm_wr_mem_address", {1'b0, mem_address}, 16'h7FFF);
    tick();
    chk1("unm_wr_bad_pulse", bad_addr, 1'b0);

    // Back-to-back: an A write to 0x4000 followed by a B read of 0x4000 in the next cycle
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h4000; a_wdata = 16'hAAAA;
    tick();
    a_req = 1'b0; a_we = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 15'h4000; #1;
    chk1("b2b_b_gnt", b_gnt, 1'b1);
    chk1("b2b_mem_load", mem_load, 1'b1);
    tick();
    b_req = 1'b0;
    tick();
    chk1("b2b_b_rvalid", b_rvalid, 1'b1);
    chk16("b2b_b_rdata", b_rdata, 16'hAAAA);
    chk1("b2b_a_rvalid", a_rvalid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
